mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter that shares a single memory port between the CPU path (via mmio_fabric RAM window) and the DMA engine.
- Lets the SoC replace the dual-port BRAM with a single-port RAM, or share port A with a second requester.
- Uses the standard mem handshake (req/we/addr/wdata/rdata/ready) on every side.
- Provides round-robin or fixed-priority-with-anti-starvation arbitration, plus a saturating contention counter for debug MMIO.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
RR_ENABLE, 1, 1 = round-robin; 0 = fixed priority, m0 wins
STARVE_LIMIT, 4, fixed-priority mode only: max consecutive m0 grants while m1 is waiting, then m1 is forced

Ports:
clk  in  1  system clock (sys_clk domain)
rst  in  1  synchronous, active-high reset
m0_mem_req  in  1  master 0 (CPU/fabric) request, held until ready
m0_mem_we  in  1  master 0 write enable
m0_mem_addr  in  ADDR_WIDTH  master 0 address
m0_mem_wdata  in  DATA_WIDTH  master 0 write data
m0_mem_rdata  out  DATA_WIDTH  master 0 read data, valid with m0_mem_ready
m0_mem_ready  out  1  master 0 completion pulse
m1_mem_req / m1_mem_we / m1_mem_addr / m1_mem_wdata / m1_mem_rdata / m1_mem_ready: master 1 (DMA), same widths and meaning as m0
s_mem_req  out  1  slave request
s_mem_we  out  1  slave write enable (latched)
s_mem_addr  out  ADDR_WIDTH  slave address (latched)
s_mem_wdata  out  DATA_WIDTH  slave write data (latched)
s_mem_rdata  in  DATA_WIDTH  slave read data
s_mem_ready  in  1  slave completion pulse
grant  out  2  one-hot owner ({m1,m0}); valid only in BUSY, else 0
contention_cnt  out  16  count of arbitrations with both masters requesting; saturates at 16'hFFFF

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- State machine: IDLE and BUSY.
- Reset values: state=IDLE, last_owner=1 (so m0 wins the first tie), starve_cnt=0, contention_cnt=0, grant=0, s_mem_req=0, latched we/addr/wdata=0, m0/m1 ready=0, rdata=0.
- IDLE, no request: stay in IDLE.
- IDLE, request present:
  - Pick a winner and latch its we/addr/wdata into s_mem_* registers.
  - Set owner and grant; go to BUSY.
  - s_mem_req rises the next cycle. Latency is request at cycle N, s_mem_req at N+1.
- Arbitration when only one master requests: that master wins.
- Arbitration when both request:
  - RR_ENABLE=1: the master != last_owner wins.
  - RR_ENABLE=0: m0 wins unless starve_cnt==STARVE_LIMIT, in which case m1 wins.
- starve_cnt (fixed-priority mode):
  - Increments (saturating) on each m0 grant made while m1_mem_req=1.
  - Clears on any m1 grant, and on any m0 grant while m1 is idle.
- contention_cnt: +1 on each IDLE arbitration where both requests are high; holds at 16'hFFFF.
- BUSY:
  - s_mem_req=1 and s_mem_* hold their latched values.
  - Owner's mX_mem_rdata = s_mem_rdata (combinational).
  - Non-owner rdata=0 and its ready=0.
- Completion: on s_mem_ready=1 in BUSY:
  - Owner's mX_mem_ready=1 in the same cycle.
  - last_owner <= owner; next state IDLE, grant <= 0, s_mem_req <= 0.
- Throughput: one transaction per 2 cycles minimum (IDLE arbitration bubble). A master holding req high in the cycle after its ready is a new transaction.
- s_mem_ready while IDLE: ignored, no master ready.
- Master drops req mid-transaction (protocol violation): the latched transaction still completes. The ready pulse is still issued to the recorded owner.
- Master inputs changing during BUSY: no effect on s_mem_* (latched).
- rst asserted in BUSY: next edge forces IDLE and s_mem_req=0. The transaction is abandoned and no ready is issued. Counters clear.
- Write vs read: the arbiter does not distinguish them; same path and latency.

Test Plan:
- Single m0 read, addr 0x100, slave ready 2 cycles after s_mem_req, rdata 0xDEADBEEF: s_mem_req rises 1 cycle after m0 req; grant=01; m0_mem_ready with rdata 0xDEADBEEF; m1 ready/rdata stay 0.
- RR_ENABLE=1, m0 and m1 requesting continuously, slave ready immediately: grants alternate m0, m1, m0, m1; contention_cnt=4 after 4 transactions.
- RR_ENABLE=0, STARVE_LIMIT=4, both requesting continuously: grant order m0,m0,m0,m0,m1, repeating; m1 is never waiting more than 4 grants.
- m1 write, addr 0x2000, wdata 0x12345678; m1 addr/wdata changed to 0xFFFF/0 during BUSY: slave still sees 0x2000/0x12345678/we=1 until ready.
- rst pulsed 1 cycle while BUSY, before s_mem_ready: next cycle s_mem_req=0, grant=0, no mX_mem_ready; a later m0 request is served normally and contention_cnt=0.
- s_mem_ready pulsed while IDLE with no requests: no ready to either master; state remains IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master, one-slave memory arbiter. The winner's request is latched for the whole slave
// transaction. Arbitration is round-robin, or fixed priority with a bound on m1 starvation.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int RR_ENABLE    = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_mem_req,
    input  logic                  m0_mem_we,
    input  logic [ADDR_WIDTH-1:0] m0_mem_addr,
    input  logic [DATA_WIDTH-1:0] m0_mem_wdata,
    output logic [DATA_WIDTH-1:0] m0_mem_rdata,
    output logic                  m0_mem_ready,
    input  logic                  m1_mem_req,
    input  logic                  m1_mem_we,
    input  logic [ADDR_WIDTH-1:0] m1_mem_addr,
    input  logic [DATA_WIDTH-1:0] m1_mem_wdata,
    output logic [DATA_WIDTH-1:0] m1_mem_rdata,
    output logic                  m1_mem_ready,
    output logic                  s_mem_req,
    output logic                  s_mem_we,
    output logic [ADDR_WIDTH-1:0] s_mem_addr,
    output logic [DATA_WIDTH-1:0] s_mem_wdata,
    input  logic [DATA_WIDTH-1:0] s_mem_rdata,
    input  logic                  s_mem_ready,
    output logic [1:0]            grant,
    output logic [15:0]           contention_cnt
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic [15:0]           cont_q, cont_d;
    logic [1:0]            grant_q, grant_d;
    logic                  s_req_q, s_req_d;
    logic                  s_we_q, s_we_d;
    logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
    logic [DATA_WIDTH-1:0] s_wdata_q, s_wdata_d;
    logic                  win_m1;
    logic                  both_req;

    assign both_req = m0_mem_req & m1_mem_req;

    // Winner selection for an IDLE arbitration (1 = m1)
    always_comb begin
        win_m1 = 1'b0;
        if (both_req) begin
            if (RR_ENABLE != 0) begin
                win_m1 = ~last_owner_q;
            end else begin
                win_m1 = (starve_q == STARVE_MAX);
            end
        end else begin
            win_m1 = m1_mem_req;
        end
    end

    // Next-state logic for the arbitration FSM and its latched slave request
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        starve_d     = starve_q;
        cont_d       = cont_q;
        grant_d      = grant_q;
        s_req_d      = s_req_q;
        s_we_d       = s_we_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_mem_req | m1_mem_req) begin
                    state_d   = ST_BUSY;
                    owner_d   = win_m1;
                    grant_d   = win_m1 ? 2'b10 : 2'b01;
                    s_req_d   = 1'b1;
                    s_we_d    = win_m1 ? m1_mem_we    : m0_mem_we;
                    s_addr_d  = win_m1 ? m1_mem_addr  : m0_mem_addr;
                    s_wdata_d = win_m1 ? m1_mem_wdata : m0_mem_wdata;
                    if (both_req && (cont_q != 16'hFFFF)) begin
                        cont_d = cont_q + 16'd1;
                    end else begin
                        cont_d = cont_q;
                    end
                    // Counts m0 wins that left m1 waiting; any other grant restarts it
                    if (!win_m1 && m1_mem_req) begin
                        starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
                    end else begin
                        starve_d = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (s_mem_ready) begin
                    state_d      = ST_IDLE;
                    grant_d      = 2'b00;
                    s_req_d      = 1'b0;
                    last_owner_d = owner_q;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
                s_req_d = 1'b0;
            end
        endcase
    end

    // State and latched-request registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            starve_q     <= '0;
            cont_q       <= 16'd0;
            grant_q      <= 2'b00;
            s_req_q      <= 1'b0;
            s_we_q       <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            starve_q     <= starve_d;
            cont_q       <= cont_d;
            grant_q      <= grant_d;
            s_req_q      <= s_req_d;
            s_we_q       <= s_we_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
        end
    end

    // Completion and read data are routed to the owner in the same cycle as the slave responds
    always_comb begin
        m0_mem_ready = 1'b0;
        m1_mem_ready = 1'b0;
        m0_mem_rdata = '0;
        m1_mem_rdata = '0;
        if (state_q == ST_BUSY) begin
            if (owner_q) begin
                m1_mem_ready = s_mem_ready;
                m1_mem_rdata = s_mem_rdata;
            end else begin
                m0_mem_ready = s_mem_ready;
                m0_mem_rdata = s_mem_rdata;
            end
        end else begin
            m0_mem_ready = 1'b0;
            m1_mem_ready = 1'b0;
        end
    end

    assign s_mem_req      = s_req_q;
    assign s_mem_we       = s_we_q;
    assign s_mem_addr     = s_addr_q;
    assign s_mem_wdata    = s_wdata_q;
    assign grant          = grant_q;
    assign contention_cnt = cont_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance share one stimulus
// stream and are each compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] s_rdata;
    logic        s_ready;

    logic [1:0][31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [1:0]       m0_rdy, m1_rdy, s_req, s_we;
    logic [1:0][1:0]  grant;
    logic [1:0][15:0] cont;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model, index 0 = round-robin instance, 1 = fixed-priority instance
    bit          mb[2];
    int          mown[2];
    int          mlast[2];
    int          mstarve[2];
    int          mcont[2];
    logic        mwe[2];
    logic [31:0] maddr[2];
    logic [31:0] mwdata[2];
    int          gq_rr[$];
    int          gq_fp[$];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_ENABLE(1), .STARVE_LIMIT(4)) dut_rr (
        .clk(clk), .rst(rst),
        .m0_mem_req(m0_req), .m0_mem_we(m0_we), .m0_mem_addr(m0_addr), .m0_mem_wdata(m0_wdata),
        .m0_mem_rdata(m0_rdata[0]), .m0_mem_ready(m0_rdy[0]),
        .m1_mem_req(m1_req), .m1_mem_we(m1_we), .m1_mem_addr(m1_addr), .m1_mem_wdata(m1_wdata),
        .m1_mem_rdata(m1_rdata[0]), .m1_mem_ready(m1_rdy[0]),
        .s_mem_req(s_req[0]), .s_mem_we(s_we[0]), .s_mem_addr(s_addr[0]), .s_mem_wdata(s_wdata[0]),
        .s_mem_rdata(s_rdata), .s_mem_ready(s_ready),
        .grant(grant[0]), .contention_cnt(cont[0])
    );

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_ENABLE(0), .STARVE_LIMIT(4)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_mem_req(m0_req), .m0_mem_we(m0_we), .m0_mem_addr(m0_addr), .m0_mem_wdata(m0_wdata),
        .m0_mem_rdata(m0_rdata[1]), .m0_mem_ready(m0_rdy[1]),
        .m1_mem_req(m1_req), .m1_mem_we(m1_we), .m1_mem_addr(m1_addr), .m1_mem_wdata(m1_wdata),
        .m1_mem_rdata(m1_rdata[1]), .m1_mem_ready(m1_rdy[1]),
        .s_mem_req(s_req[1]), .s_mem_we(s_we[1]), .s_mem_addr(s_addr[1]), .s_mem_wdata(s_wdata[1]),
        .s_mem_rdata(s_rdata), .s_mem_ready(s_ready),
        .grant(grant[1]), .contention_cnt(cont[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            mb[k] = 0; mown[k] = 0; mlast[k] = 1; mstarve[k] = 0; mcont[k] = 0;
            mwe[k] = 1'b0; maddr[k] = 32'd0; mwdata[k] = 32'd0;
        end
    endfunction

    // Who the rules say should win this arbitration
    function automatic int pick(input int k, input bit r0, input bit r1);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (k == 0) return 1 - mlast[0];
        return (mstarve[1] == 4) ? 1 : 0;
    endfunction

    function automatic void model_step();
        int w;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (!mb[k]) begin
                if (m0_req || m1_req) begin
                    w = pick(k, m0_req, m1_req);
                    if (m0_req && m1_req && mcont[k] < 65535) mcont[k]++;
                    if (w == 0 && m1_req) mstarve[k] = (mstarve[k] < 4) ? mstarve[k] + 1 : 4;
                    else mstarve[k] = 0;
                    mb[k] = 1; mown[k] = w;
                    mwe[k]    = (w == 1) ? m1_we    : m0_we;
                    maddr[k]  = (w == 1) ? m1_addr  : m0_addr;
                    mwdata[k] = (w == 1) ? m1_wdata : m0_wdata;
                end
            end else if (s_ready) begin
                mb[k] = 0;
                mlast[k] = mown[k];
            end
        end
    endfunction

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            bit own0, own1;
            own0 = mb[k] && mown[k] == 0;
            own1 = mb[k] && mown[k] == 1;
            chk($sformatf("d%0d_s_req", k), s_req[k], mb[k]);
            chk($sformatf("d%0d_grant", k), grant[k], own1 ? 2'b10 : (own0 ? 2'b01 : 2'b00));
            chk($sformatf("d%0d_m0_ready", k), m0_rdy[k], own0 & s_ready);
            chk($sformatf("d%0d_m1_ready", k), m1_rdy[k], own1 & s_ready);
            chk($sformatf("d%0d_m0_rdata", k), m0_rdata[k], own0 ? s_rdata : 32'd0);
            chk($sformatf("d%0d_m1_rdata", k), m1_rdata[k], own1 ? s_rdata : 32'd0);
            chk($sformatf("d%0d_cont", k), cont[k], mcont[k]);
            if (mb[k]) begin
                chk($sformatf("d%0d_s_we", k), s_we[k], mwe[k]);
                chk($sformatf("d%0d_s_addr", k), s_addr[k], maddr[k]);
                chk($sformatf("d%0d_s_wdata", k), s_wdata[k], mwdata[k]);
            end
        end
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rising edge
    task automatic cyc();
        @(negedge clk);
        check_all();
        if (grant[0] != 2'b00) gq_rr.push_back(int'(grant[0]));
        if (grant[1] != 2'b00) gq_fp.push_back(int'(grant[1]));
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_rr[4];
        int exp_fp[10];
        exp_rr = '{1, 2, 1, 2};
        exp_fp = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

        rst = 1'b1; s_ready = 1'b0; s_rdata = 32'd0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
        model_reset();
        cyc(); cyc();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_d%0d_s_we", k), s_we[k], 1'b0);
            chk($sformatf("rst_d%0d_s_addr", k), s_addr[k], 32'd0);
            chk($sformatf("rst_d%0d_s_wdata", k), s_wdata[k], 32'd0);
        end

        // Single m0 read at 0x100, slave answers two cycles after s_mem_req
        m0_req = 1'b1; m0_addr = 32'h100;
        #1 chk("m0rd_req_lat0", s_req[0], 1'b0);
        cyc();
        #1 chk("m0rd_req_lat1", s_req[0], 1'b1);
        chk("m0rd_grant", grant[0], 2'b01);
        cyc(); cyc();
        s_ready = 1'b1; s_rdata = 32'hDEADBEEF;
        #1 chk("m0rd_ready", m0_rdy[0], 1'b1);
        chk("m0rd_rdata", m0_rdata[0], 32'hDEADBEEF);
        chk("m0rd_m1_ready", m1_rdy[0], 1'b0);
        cyc();
        m0_req = 1'b0; s_ready = 1'b0;
        cyc();

        // Both masters continuously requesting, slave always ready
        rst = 1'b1; cyc(); rst = 1'b0;
        gq_rr.delete(); gq_fp.delete();
        m0_req = 1'b1; m1_req = 1'b1; s_ready = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        chk("rr_cont4", cont[0], 16'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), gq_rr[i], exp_rr[i]);
        for (int i = 0; i < 12; i++) cyc();
        for (int i = 0; i < 10; i++) chk($sformatf("fp_order%0d", i), gq_fp[i], exp_fp[i]);
        m0_req = 1'b0; m1_req = 1'b0; s_ready = 1'b0;
        cyc(); cyc();

        // m1 write whose inputs change while the slave transaction is in flight
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h2000; m1_wdata = 32'h12345678;
        cyc();
        m1_addr = 32'h0000FFFF; m1_wdata = 32'd0; m1_we = 1'b0;
        #1 chk("m1wr_addr", s_addr[0], 32'h2000);
        chk("m1wr_wdata", s_wdata[0], 32'h12345678);
        chk("m1wr_we", s_we[0], 1'b1);
        cyc(); cyc();
        s_ready = 1'b1; cyc();
        m1_req = 1'b0; s_ready = 1'b0; cyc();

        // Reset while busy abandons the transaction
        m0_req = 1'b1; m1_req = 1'b1; cyc();
        m1_req = 1'b0; rst = 1'b1; cyc();
        rst = 1'b0; m0_req = 1'b0;
        #1 chk("rstbusy_s_req", s_req[0], 1'b0);
        chk("rstbusy_grant", grant[1], 2'b00);
        chk("rstbusy_cont", cont[0], 16'd0);
        cyc();
        m0_req = 1'b1; cyc();
        s_ready = 1'b1;
        #1 chk("rstbusy_serve", m0_rdy[0], 1'b1);
        cyc();
        m0_req = 1'b0; s_ready = 1'b0; cyc();

        // Slave ready while idle is ignored
        s_ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        s_ready = 1'b0; cyc();

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            m0_req   = ($urandom_range(0, 2) != 0);
            m1_req   = ($urandom_range(0, 2) != 0);
            m0_we    = $urandom_range(0, 1);
            m1_we    = $urandom_range(0, 1);
            m0_addr  = $urandom; m1_addr = $urandom;
            m0_wdata = $urandom; m1_wdata = $urandom;
            s_rdata  = $urandom;
            s_ready  = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
